// File: rtl/reg_file_flags.sv
// reg_file_flags: DEPTH x WIDTH register file with two combinational read
// ports, one synchronous write port and a carry/zero flag register.
// Register 0 is hardwired to zero.
// Optional feature macro: RF_WRITE_BYPASS_EN forwards a same-cycle write
// to the read ports (write-before-read); when undefined the read ports see
// the array only.
`timescale 1ns/1ps

module reg_file_flags #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(DEPTH)-1:0] ra_addr,
  input  logic [$clog2(DEPTH)-1:0] rb_addr,
  output logic [WIDTH-1:0]         ra_data,
  output logic [WIDTH-1:0]         rb_data,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] w_addr,
  input  logic [WIDTH-1:0]         w_data,
  input  logic                     flag_we,
  input  logic                     c_in,
  input  logic                     z_in,
  output logic                     carry_flag,
  output logic                     zero_flag
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_regs [DEPTH];
  logic             r_carry;
  logic             r_zero;

  logic             w_wr_ok;
  logic [WIDTH-1:0] w_ra;
  logic [WIDTH-1:0] w_rb;

  // A write is only committed for non-zero addresses; entry 0 stays zero.
  assign w_wr_ok = we && (w_addr != '0);

  // Storage array: async clear, synchronous write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_regs[w_addr] <= w_data;
    end
  end

  // Flag register: C and Z always update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
    end else if (flag_we) begin
      r_carry <= c_in;
      r_zero  <= z_in;
    end
  end

  // Read port A: array lookup, optional write forwarding, address 0 forced to zero.
  always_comb begin
    w_ra = r_regs[ra_addr];
`ifdef RF_WRITE_BYPASS_EN
    // Forwarding is suppressed while reset is held so the ports read zero.
    if (rst_n && w_wr_ok && (ra_addr == w_addr)) begin
      w_ra = w_data;
    end
`endif
    if (ra_addr == AW'(0)) begin
      w_ra = '0;
    end
  end

  // Read port B: identical structure to port A.
  always_comb begin
    w_rb = r_regs[rb_addr];
`ifdef RF_WRITE_BYPASS_EN
    if (rst_n && w_wr_ok && (rb_addr == w_addr)) begin
      w_rb = w_data;
    end
`endif
    if (rb_addr == AW'(0)) begin
      w_rb = '0;
    end
  end

  assign ra_data    = w_ra;
  assign rb_data    = w_rb;
  assign carry_flag = r_carry;
  assign zero_flag  = r_zero;

endmodule

// File: tb/tb_reg_file_flags.sv
// Self-checking bench for reg_file_flags: directed literal checks plus
// randomized traffic compared every cycle against a behavioural model.
// Honours RF_WRITE_BYPASS_EN the same way the design does.
`timescale 1ns/1ps

module tb_reg_file_flags;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] ra_addr, rb_addr, w_addr;
  logic [7:0] ra_data, rb_data, w_data;
  logic       we, flag_we, c_in, z_in;
  logic       carry_flag, zero_flag;

  int n_tests = 0;
  int n_fail  = 0;
  logic cmp_en = 1'b0;

`ifdef RF_WRITE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  reg_file_flags #(.DEPTH(8), .WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ra_addr    (ra_addr),
    .rb_addr    (rb_addr),
    .ra_data    (ra_data),
    .rb_data    (rb_data),
    .we         (we),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .flag_we    (flag_we),
    .c_in       (c_in),
    .z_in       (z_in),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag)
  );

  always #5 clk = ~clk;

  // Behavioural model: plain array plus two flag bits.
  logic [7:0] m_mem [8] = '{default: 8'h00};
  logic       m_c = 1'b0;
  logic       m_z = 1'b0;

  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      if (we && w_addr != 3'd0) m_mem[w_addr] = w_data;
      if (flag_we) begin
        m_c = c_in;
        m_z = z_in;
      end
    end
  end

  always @(negedge rst_n) begin
    for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
    m_c = 1'b0;
    m_z = 1'b0;
  end

  function automatic logic [7:0] exp_read(input logic [2:0] a);
    if (rst_n !== 1'b1 || a == 3'd0) return 8'h00;
    if (BYPASS && we && w_addr != 3'd0 && w_addr == a) return w_data;
    return m_mem[a];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_ra", {24'd0, ra_data}, {24'd0, exp_read(ra_addr)});
      chk("cyc_rb", {24'd0, rb_data}, {24'd0, exp_read(rb_addr)});
      chk("cyc_c",  {31'd0, carry_flag}, {31'd0, m_c});
      chk("cyc_z",  {31'd0, zero_flag},  {31'd0, m_z});
    end
  end

  task automatic drive(input logic iwe, input logic [2:0] iwa, input logic [7:0] iwd,
                       input logic ifwe, input logic ic, input logic iz,
                       input logic [2:0] ira, input logic [2:0] irb);
    we = iwe; w_addr = iwa; w_data = iwd;
    flag_we = ifwe; c_in = ic; z_in = iz;
    ra_addr = ira; rb_addr = irb;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_init_c", {31'd0, carry_flag}, 32'd0);
    chk("rst_init_z", {31'd0, zero_flag}, 32'd0);
    #11 rst_n = 1'b1;
    cmp_en = 1'b1;
    step();

    // Fill everything with FF and set both flags.
    for (int i = 1; i < 8; i++) begin
      drive(1, 3'(i), 8'hFF, 1, 1, 1, 3'(i), 3'(i));
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 3'd5, 3'd6);
    #1;
    chk("fill_ra", {24'd0, ra_data}, 32'hFF);
    chk("fill_c",  {31'd0, carry_flag}, 32'd1);

    // Mid-cycle asynchronous reset: outputs clear without a clock edge.
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      ra_addr = 3'(i); rb_addr = 3'(7 - i);
      #1;
      chk("rst_ra", {24'd0, ra_data}, 32'd0);
      chk("rst_rb", {24'd0, rb_data}, 32'd0);
    end
    chk("rst_c", {31'd0, carry_flag}, 32'd0);
    chk("rst_z", {31'd0, zero_flag}, 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    step();

    // Write/read all registers on each port separately.
    for (int i = 1; i < 8; i++) begin
      drive(1, 3'(i), 8'(8'h10 + i), 0, 0, 0, 0, 0);
      step();
    end
    drive(1, 3'd0, 8'hAA, 0, 0, 0, 3'd0, 3'd0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      ra_addr = 3'(i); rb_addr = 3'd0;
      #1;
      chk("wr_a", {24'd0, ra_data}, (i == 0) ? 32'h00 : 32'(8'h10 + i));
    end
    for (int i = 0; i < 8; i++) begin
      ra_addr = 3'd0; rb_addr = 3'(i);
      #1;
      chk("wr_b", {24'd0, rb_data}, (i == 0) ? 32'h00 : 32'(8'h10 + i));
    end
    step();

    // Same-cycle read of the register being written.
    drive(1, 3'd3, 8'h05, 0, 0, 0, 3'd3, 3'd3);
    step();
    drive(1, 3'd3, 8'h3C, 0, 0, 0, 3'd3, 3'd3);
    #1;
    chk("same_pre_a", {24'd0, ra_data}, BYPASS ? 32'h3C : 32'h05);
    chk("same_pre_b", {24'd0, rb_data}, BYPASS ? 32'h3C : 32'h05);
    step();
    drive(0, 0, 0, 0, 0, 0, 3'd3, 3'd3);
    #1;
    chk("same_post_a", {24'd0, ra_data}, 32'h3C);
    chk("same_post_b", {24'd0, rb_data}, 32'h3C);

    // Flag update, hold, update.
    drive(0, 0, 0, 1, 1, 0, 0, 0);
    step();
    chk("flg1_c", {31'd0, carry_flag}, 32'd1);
    chk("flg1_z", {31'd0, zero_flag}, 32'd0);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    step();
    chk("flg_hold_c", {31'd0, carry_flag}, 32'd1);
    chk("flg_hold_z", {31'd0, zero_flag}, 32'd0);
    drive(0, 0, 0, 1, 0, 1, 0, 0);
    step();
    chk("flg2_c", {31'd0, carry_flag}, 32'd0);
    chk("flg2_z", {31'd0, zero_flag}, 32'd1);

    // Simultaneous register write and flag update.
    drive(1, 3'd7, 8'h80, 1, 1, 1, 3'd7, 3'd0);
    step();
    drive(0, 0, 0, 0, 0, 0, 3'd7, 3'd0);
    #1;
    chk("sim_r7", {24'd0, ra_data}, 32'h80);
    chk("sim_c", {31'd0, carry_flag}, 32'd1);
    chk("sim_z", {31'd0, zero_flag}, 32'd1);

    // Reset coincident with an enabled write: the write is lost.
    drive(1, 3'd2, 8'h77, 1, 1, 0, 3'd2, 3'd2);
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    chk("rmo_hold", {24'd0, ra_data}, 32'h00);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 3'd2, 3'd2);
    #1;
    chk("rmo_r2", {24'd0, ra_data}, 32'h00);
    chk("rmo_c", {31'd0, carry_flag}, 32'd0);
    step();
    drive(1, 3'd2, 8'h5A, 0, 0, 0, 3'd2, 3'd2);
    step();
    drive(0, 0, 0, 0, 0, 0, 3'd2, 3'd2);
    #1;
    chk("rmo_post", {24'd0, rb_data}, 32'h5A);

    // Randomized traffic with occasional mid-cycle resets.
    for (int n = 0; n < 600; n++) begin
      drive(($urandom % 10) < 6, 3'($urandom), 8'($urandom),
            ($urandom % 3) == 0, 1'($urandom), 1'($urandom),
            3'($urandom), 3'($urandom));
      if ($urandom_range(0, 49) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
      end
      step();
    end

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
